// File: rtl/lock_access_scheduler_pkg.sv
// Shared encodings for the lock access scheduler: FSM states, grant sources,
// beep pattern codes, plus a counter-width helper.
package lock_access_scheduler_pkg;

  localparam logic [1:0] ST_CLOSED  = 2'd0;
  localparam logic [1:0] ST_OPENING = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_CLOSING = 2'd3;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_UART = 2'b01;
  localparam logic [1:0] GRANT_BTN  = 2'b10;

  localparam logic [1:0] PAT_NONE = 2'd0;
  localparam logic [1:0] PAT_ONE  = 2'd1;
  localparam logic [1:0] PAT_TWO  = 2'd2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_access_scheduler_beep_sequencer.sv
// Buzzer pattern generator: ONE = single beep, TWO = beep, gap, beep.
// A start pulse aborts whatever pattern is running and begins the new one.
module beep_sequencer
  import lock_access_scheduler_pkg::*;
#(
  parameter int unsigned BEEP_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] pattern,
  output logic       buzzer
);

  localparam int unsigned CNT_W = cnt_w(max_u(BEEP_CYCLES, GAP_CYCLES));
  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_BEEP = 2'd1;
  localparam logic [1:0] PH_GAP  = 2'd2;

  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idx_q, idx_d;
  logic             two_q, two_d;
  logic             buzzer_q, buzzer_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    two_d    = two_q;
    buzzer_d = buzzer_q;
    if (start) begin
      cnt_d = '0;
      idx_d = 1'b0;
      two_d = (pattern == PAT_TWO);
      if (pattern == PAT_ONE || pattern == PAT_TWO) begin
        phase_d  = PH_BEEP;
        buzzer_d = 1'b1;
      end else begin
        phase_d  = PH_IDLE;
        buzzer_d = 1'b0;
      end
    end else begin
      case (phase_q)
        PH_BEEP: begin
          if (cnt_q == BEEP_LAST) begin
            cnt_d    = '0;
            buzzer_d = 1'b0;
            phase_d  = (two_q && !idx_q) ? PH_GAP : PH_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PH_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d    = '0;
            idx_d    = 1'b1;
            buzzer_d = 1'b1;
            phase_d  = PH_BEEP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          buzzer_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      idx_q    <= 1'b0;
      two_q    <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      two_q    <= two_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;

endmodule

// File: rtl/lock_access_scheduler.sv
// Door-lock sequencer: arbitrates UART/button requests, holds the servo through
// the settle window and drives beeps. Define AUTO_RELOCK_EN for the OPEN timeout.
module lock_access_scheduler
  import lock_access_scheduler_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 25_000_000,
  parameter int unsigned OPEN_CYCLES   = 250_000_000,
  parameter int unsigned BEEP_CYCLES   = 5_000_000,
  parameter int unsigned GAP_CYCLES    = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_open_req,
  input  logic       uart_close_req,
  input  logic       btn_req,
  output logic       pos_sel,
  output logic       busy,
  output logic [1:0] grant_src,
  output logic       req_drop,
  output logic       buzzer
);

  // A beep pattern must always finish before the lock is back at rest.
  if (SETTLE_CYCLES < 2 * BEEP_CYCLES + GAP_CYCLES || OPEN_CYCLES < 1) begin : g_bad_cfg
    $error("lock_access_scheduler: invalid timing parameters");
  end

`ifdef AUTO_RELOCK_EN
  localparam int unsigned CNT_W = cnt_w(max_u(SETTLE_CYCLES, OPEN_CYCLES));
  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
`else
  localparam int unsigned CNT_W = cnt_w(SETTLE_CYCLES);
`endif
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pos_sel_q, pos_sel_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant_q, grant_d;
  logic             drop_q, drop_d;
  logic             beep_start;
  logic [1:0]       beep_pat;
  logic             any_req;

  assign any_req = uart_open_req | uart_close_req | btn_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_sel_d  = pos_sel_q;
    grant_d    = grant_q;
    drop_d     = 1'b0;
    beep_start = 1'b0;
    beep_pat   = PAT_NONE;
    case (state_q)
      ST_CLOSED: begin
        // A lone close command is a no-op here; open beats button.
        if (uart_open_req || btn_req) begin
          state_d    = ST_OPENING;
          cnt_d      = '0;
          pos_sel_d  = 1'b1;
          grant_d    = uart_open_req ? GRANT_UART : GRANT_BTN;
          beep_start = 1'b1;
          beep_pat   = PAT_ONE;
        end
      end
      ST_OPENING, ST_CLOSING: begin
        drop_d = any_req;
        if (cnt_q == SETTLE_LAST) begin
          state_d = (state_q == ST_OPENING) ? ST_OPEN : ST_CLOSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // OPEN: close beats button; button beats a relock restart.
        if (uart_close_req || btn_req) begin
          state_d    = ST_CLOSING;
          cnt_d      = '0;
          pos_sel_d  = 1'b0;
          grant_d    = uart_close_req ? GRANT_UART : GRANT_BTN;
          beep_start = 1'b1;
          beep_pat   = PAT_TWO;
        end
`ifdef AUTO_RELOCK_EN
        else if (uart_open_req) begin
          cnt_d = '0;
        end else if (cnt_q == OPEN_LAST) begin
          state_d    = ST_CLOSING;
          cnt_d      = '0;
          pos_sel_d  = 1'b0;
          grant_d    = GRANT_NONE;
          beep_start = 1'b1;
          beep_pat   = PAT_TWO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
    endcase
    busy_d = (state_d == ST_OPENING) || (state_d == ST_CLOSING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLOSED;
      cnt_q     <= '0;
      pos_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      grant_q   <= GRANT_NONE;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_sel_q <= pos_sel_d;
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      drop_q    <= drop_d;
    end
  end

  beep_sequencer #(
    .BEEP_CYCLES(BEEP_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_beep (
    .clk    (clk),
    .rst    (rst),
    .start  (beep_start),
    .pattern(beep_pat),
    .buzzer (buzzer)
  );

  assign pos_sel   = pos_sel_q;
  assign busy      = busy_q;
  assign grant_src = grant_q;
  assign req_drop  = drop_q;

endmodule

// File: tb/tb_lock_access_scheduler.sv
// Self-checking bench for lock_access_scheduler: directed scenarios then random
// single-cycle requests, all checked against a cycle-stamp reference model.
module tb_lock_access_scheduler;

  localparam int SETTLE = 20;
  localparam int OPEN   = 100;
  localparam int BEEP   = 4;
  localparam int GAP    = 3;

  logic       clk;
  logic       rst;
  logic       uart_open_req;
  logic       uart_close_req;
  logic       btn_req;
  logic       pos_sel;
  logic       busy;
  logic [1:0] grant_src;
  logic       req_drop;
  logic       buzzer;

  lock_access_scheduler #(
    .SETTLE_CYCLES(SETTLE),
    .OPEN_CYCLES  (OPEN),
    .BEEP_CYCLES  (BEEP),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_open_req (uart_open_req),
    .uart_close_req(uart_close_req),
    .btn_req       (btn_req),
    .pos_sel       (pos_sel),
    .busy          (busy),
    .grant_src     (grant_src),
    .req_drop      (req_drop),
    .buzzer        (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int cyc;

  // Reference model: event cycle stamps rather than a state machine.
  bit         m_open;
  int         acc;
  int         beep_at;
  bit         beep_two;
  logic [1:0] m_grant;
  bit         m_drop;
  int         timer_ref;

  function automatic bit moving(input int n);
    return (n > acc) && (n <= acc + SETTLE);
  endfunction

  function automatic bit buzz(input int n);
    int k;
    k = n - beep_at;
    if (k >= 1 && k <= BEEP) return 1'b1;
    if (beep_two && k >= BEEP + GAP + 1 && k <= 2 * BEEP + GAP) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_open    = 1'b0;
    acc       = -1000;
    beep_at   = -1000;
    beep_two  = 1'b0;
    m_grant   = 2'b00;
    m_drop    = 1'b0;
    timer_ref = 0;
  endtask

  task automatic model_close(input int n, input logic [1:0] g);
    m_open   = 1'b0;
    acc      = n;
    m_grant  = g;
    beep_at  = n;
    beep_two = 1'b1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("pos_sel",   {1'b0, pos_sel},  {1'b0, m_open});
    check("busy",      {1'b0, busy},     {1'b0, moving(cyc)});
    check("grant_src", grant_src,        m_grant);
    check("req_drop",  {1'b0, req_drop}, {1'b0, m_drop});
    check("buzzer",    {1'b0, buzzer},   {1'b0, buzz(cyc)});
  endtask

  // One clock cycle: apply requests, advance the model, check after the edge.
  task automatic step(input bit i_uo, input bit i_uc, input bit i_b);
    int n;
    n = cyc;
    uart_open_req  = i_uo;
    uart_close_req = i_uc;
    btn_req        = i_b;
    m_drop = 1'b0;
    if (moving(n)) begin
      m_drop = i_uo | i_uc | i_b;
    end else if (!m_open) begin
      if (i_uo || i_b) begin
        m_open    = 1'b1;
        acc       = n;
        m_grant   = i_uo ? 2'b01 : 2'b10;
        beep_at   = n;
        beep_two  = 1'b0;
        timer_ref = n + SETTLE + 1;
      end
    end else begin
      if (i_uc) model_close(n, 2'b01);
      else if (i_b) model_close(n, 2'b10);
`ifdef AUTO_RELOCK_EN
      else if (i_uo) timer_ref = n + 1;
      else if (n - timer_ref == OPEN - 1) model_close(n, 2'b00);
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    uart_open_req  = 1'b0;
    uart_close_req = 1'b0;
    btn_req        = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  logic [11:0] exp_pat;

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst            = 1'b0;
    uart_open_req  = 1'b0;
    uart_close_req = 1'b0;
    btn_req        = 1'b0;
    model_reset();

    // Reset values
    #3;
    check("rst_pos_sel", {1'b0, pos_sel}, 2'b00);
    check("rst_busy",    {1'b0, busy},    2'b00);
    check("rst_buzzer",  {1'b0, buzzer},  2'b00);
    check("rst_grant",   grant_src,       2'b00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all();

    // UART open: outputs from t0+1, busy low at t0+21
    step(1'b1, 1'b0, 1'b0);
    check("open_grant", grant_src, 2'b01);
    check("open_busy",  {1'b0, busy}, 2'b01);
    idle(19);
    check("busy_t0p20", {1'b0, busy}, 2'b01);
    idle(1);
    check("busy_t0p21", {1'b0, busy}, 2'b00);

    // Button close: two-beep pattern
    exp_pat = 12'b1111_0001_1110;
    step(1'b0, 1'b0, 1'b1);
    check("close_beep", {1'b0, buzzer}, {1'b0, exp_pat[11]});
    check("close_pos_sel", {1'b0, pos_sel}, 2'b00);
    check("close_grant", grant_src, 2'b10);
    for (int i = 1; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("close_beep", {1'b0, buzzer}, {1'b0, exp_pat[11-i]});
    end
    idle(SETTLE);

    // All three requests in OPEN: close wins, nothing dropped
    step(1'b0, 1'b0, 1'b1);
    idle(SETTLE);
    step(1'b1, 1'b1, 1'b1);
    check("triple_grant", grant_src, 2'b01);
    check("triple_drop",  {1'b0, req_drop}, 2'b00);
    check("triple_pos",   {1'b0, pos_sel}, 2'b00);
    idle(SETTLE);

    // Button while OPENING: one drop pulse, schedule unaffected
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    check("drop_pulse", {1'b0, req_drop}, 2'b01);
    check("drop_pos",   {1'b0, pos_sel},  2'b01);
    step(1'b0, 1'b0, 1'b0);
    check("drop_end",   {1'b0, req_drop}, 2'b00);
    idle(SETTLE);
    check("drop_open",  {1'b0, busy}, 2'b00);

`ifdef AUTO_RELOCK_EN
    // Idle relock after OPEN cycles, then relock restarted at cycle 60
    step(1'b0, 1'b1, 1'b0);
    idle(SETTLE);
    step(1'b1, 1'b0, 1'b0);
    idle(SETTLE + OPEN - 1);
    check("relock_hold", {1'b0, pos_sel}, 2'b01);
    step(1'b0, 1'b0, 1'b0);
    check("relock_pos",   {1'b0, pos_sel}, 2'b00);
    check("relock_grant", grant_src, 2'b00);
    idle(SETTLE);
    step(1'b1, 1'b0, 1'b0);
    idle(SETTLE + 60);
    step(1'b1, 1'b0, 1'b0);
    idle(OPEN - 1);
    check("restart_hold", {1'b0, pos_sel}, 2'b01);
    step(1'b0, 1'b0, 1'b0);
    check("restart_pos", {1'b0, pos_sel}, 2'b00);
    idle(SETTLE);
`else
    // No relock timer: OPEN holds
    idle(1000);
    check("hold_open", {1'b0, pos_sel}, 2'b01);
    step(1'b0, 1'b1, 1'b0);
    idle(SETTLE);
`endif

    // Reset asserted mid-OPENING
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_pos_sel", {1'b0, pos_sel},  2'b00);
    check("midrst_busy",    {1'b0, busy},     2'b00);
    check("midrst_buzzer",  {1'b0, buzzer},   2'b00);
    check("midrst_drop",    {1'b0, req_drop}, 2'b00);
    check("midrst_grant",   grant_src,        2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    idle(SETTLE + 5);

    // Random single requests (plus open+button pairs)
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 15);
      step(r == 0 || r == 3, r == 1, r == 2 || r == 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
